// File: rtl/button_event_decoder_pkg.sv
// Shared state encoding and default debounce/hold/repeat timings for the
// pushbutton event decoder and its users.
package button_event_decoder_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DB_PRESS   = 3'd1,
    S_PRESSED    = 3'd2,
    S_REPEAT     = 3'd3,
    S_DB_RELEASE = 3'd4
  } state_t;

  localparam int unsigned DEF_DB_MS     = 20;
  localparam int unsigned DEF_HOLD_MS   = 600;
  localparam int unsigned DEF_REPEAT_MS = 150;
  localparam int unsigned DEF_CNT_W     = 10;

endpackage

// File: rtl/button_event_decoder.sv
// Turns a synchronized button level into press/release/auto-repeat pulses,
// timed in 1 ms tick strobes. The release pulse is named 'released' since
// 'release' is a reserved word.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned DB_MS     = DEF_DB_MS,
  parameter int unsigned HOLD_MS   = DEF_HOLD_MS,
  parameter int unsigned REPEAT_MS = DEF_REPEAT_MS,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_ms,
  input  logic btn_sync,
  output logic press,
  output logic released,
  output logic rpt,
  output logic held
);

  localparam logic [CNT_W-1:0] DB_TC     = CNT_W'(DB_MS - 1);
  localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_MS - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_MS - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             press_n, rel_n, rpt_n, held_n;

  // A level change outranks a coincident tick: the tick is simply dropped.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press_n = 1'b0;
    rel_n   = 1'b0;
    rpt_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (btn_sync) begin
          state_n = S_DB_PRESS;
          cnt_n   = '0;
        end
      end
      S_DB_PRESS: begin
        if (!btn_sync) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (tick_ms) begin
          if (cnt == DB_TC) begin
            state_n = S_PRESSED;
            cnt_n   = '0;
            press_n = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      S_PRESSED, S_REPEAT: begin
        if (!btn_sync) begin
          state_n = S_DB_RELEASE;
          cnt_n   = '0;
        end else if (tick_ms) begin
          if (cnt == ((state == S_PRESSED) ? HOLD_TC : REPEAT_TC)) begin
            state_n = S_REPEAT;
            cnt_n   = '0;
            rpt_n   = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      S_DB_RELEASE: begin
        if (btn_sync) begin
          state_n = S_PRESSED;
          cnt_n   = '0;
        end else if (tick_ms) begin
          if (cnt == DB_TC) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            rel_n   = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    held_n = (state_n == S_PRESSED) || (state_n == S_REPEAT) ||
             (state_n == S_DB_RELEASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      press    <= 1'b0;
      released <= 1'b0;
      rpt      <= 1'b0;
      held     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      press    <= press_n;
      released <= rel_n;
      rpt      <= rpt_n;
      held     <= held_n;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with short timings
// (DB_MS=4, HOLD_MS=10, REPEAT_MS=3, one tick every 5 clk).
module tb_button_event_decoder;
  import button_event_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n, tick_ms, btn_sync;
  logic press, released, rpt, held;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned tick_idx = 0;
  int unsigned n_press, n_rel, n_rpt, excl_err;
  int unsigned press_tick, rel_tick, t0;
  logic        rel_held;

  always #5 clk = ~clk;

  button_event_decoder #(
    .DB_MS    (4),
    .HOLD_MS  (10),
    .REPEAT_MS(3),
    .CNT_W    (10)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_ms (tick_ms),
    .btn_sync(btn_sync),
    .press   (press),
    .released(released),
    .rpt     (rpt),
    .held    (held)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_rpt = 0;
  endtask

  // One clock; samples outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (tick_ms) tick_idx++;
    if (press) begin n_press++; press_tick = tick_idx; end
    if (released) begin n_rel++; rel_tick = tick_idx; rel_held = held; end
    if (rpt) n_rpt++;
    if (int'(press) + int'(released) + int'(rpt) > 1) excl_err++;
  endtask

  task automatic run_ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tick_ms = 1'b1;
      step();
      tick_ms = 1'b0;
      repeat (4) step();
    end
  endtask

  initial begin
    rst_n = 1'b0; tick_ms = 1'b0; btn_sync = 1'b0;
    excl_err = 0; press_tick = 0; rel_tick = 0; rel_held = 1'b1;
    clear_counts();
    repeat (3) step();
    check_val("reset_outputs", {28'd0, press, released, rpt, held}, 32'd0);
    check_val("reset_state", 32'(dut.state), 32'(S_IDLE));
    rst_n = 1'b1;
    step();

    // Clean press, hold and auto-repeat
    t0 = tick_idx;
    btn_sync = 1'b1; step();
    run_ticks(3);
    check_val("press_early", n_press, 0);
    check_val("held_before_press", 32'(held), 0);
    run_ticks(1);
    check_val("press_count", n_press, 1);
    check_val("press_tick", press_tick, t0 + 4);
    check_val("held_after_press", 32'(held), 1);
    run_ticks(9);
    check_val("rpt_before_hold", n_rpt, 0);
    run_ticks(1);
    check_val("rpt_first", n_rpt, 1);
    run_ticks(3);
    check_val("rpt_second", n_rpt, 2);
    run_ticks(6);
    check_val("rpt_fourth", n_rpt, 4);

    // Clean release from REPEAT
    t0 = tick_idx;
    btn_sync = 1'b0; step();
    run_ticks(3);
    check_val("release_early", n_rel, 0);
    check_val("held_in_db_release", 32'(held), 1);
    run_ticks(2);
    check_val("release_count", n_rel, 1);
    check_val("release_tick", rel_tick, t0 + 4);
    check_val("held_falls_with_release", 32'(rel_held), 0);
    check_val("press_once_total", n_press, 1);

    // Glitch shorter than the debounce interval
    clear_counts();
    btn_sync = 1'b1; step();
    run_ticks(3);
    btn_sync = 1'b0; step();
    run_ticks(5);
    check_val("glitch_press", n_press, 0);
    check_val("glitch_release", n_rel, 0);
    check_val("glitch_held", 32'(held), 0);
    check_val("glitch_state", 32'(dut.state), 32'(S_IDLE));

    // Release bounce restarts the hold timer without a second press
    clear_counts();
    btn_sync = 1'b1; step();
    run_ticks(4);
    run_ticks(5);
    btn_sync = 1'b0; step();
    run_ticks(2);
    btn_sync = 1'b1; step();
    run_ticks(9);
    check_val("bounce_no_rpt_yet", n_rpt, 0);
    check_val("bounce_no_release", n_rel, 0);
    check_val("bounce_single_press", n_press, 1);
    check_val("bounce_held", 32'(held), 1);
    run_ticks(1);
    check_val("bounce_rpt", n_rpt, 1);

    // Back to idle, then press edge coincident with a tick
    btn_sync = 1'b0; step();
    run_ticks(4);
    check_val("bounce_release", n_rel, 1);
    clear_counts();
    t0 = tick_idx;
    btn_sync = 1'b1; tick_ms = 1'b1; step();
    tick_ms = 1'b0; repeat (4) step();
    run_ticks(3);
    check_val("collision_press_early", n_press, 0);
    run_ticks(1);
    check_val("collision_press", n_press, 1);
    check_val("collision_press_tick", press_tick, t0 + 5);

    // Asynchronous reset in the middle of a repeat pulse
    run_ticks(9);
    tick_ms = 1'b1; step(); tick_ms = 1'b0;
    check_val("pre_reset_rpt", 32'(rpt), 1);
    check_val("pre_reset_state", 32'(dut.state), 32'(S_REPEAT));
    clear_counts();
    #2 rst_n = 1'b0;
    #1;
    check_val("async_reset_outputs", {28'd0, press, released, rpt, held}, 32'd0);
    check_val("async_reset_state", 32'(dut.state), 32'(S_IDLE));
    #9 rst_n = 1'b1;
    step();
    run_ticks(3);
    check_val("post_reset_no_release", n_rel, 0);
    check_val("post_reset_press_early", n_press, 0);
    run_ticks(1);
    check_val("post_reset_press", n_press, 1);
    check_val("post_reset_held", 32'(held), 1);

    check_val("pulses_exclusive", excl_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
